// File: rtl/booth_mult_if.sv
// booth_mult_if: start/done request bus plus Booth encoder window/partial-product link.
// The master side is the multiplier controller; the slave side is the datapath/encoder environment.
interface booth_mult_if #(parameter int WIDTH = 32);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [2:0]           enc_bits;
    logic [WIDTH-1:0]     enc_m;
    logic [2*WIDTH-1:0]   enc_p;
    modport master (input start, a, b, enc_p, output busy, done, product, enc_bits, enc_m);
    modport slave  (output start, a, b, enc_p, input busy, done, product, enc_bits, enc_m);
endinterface

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential signed radix-4 Booth multiplier, two multiplier bits per cycle,
// partial products supplied by an external combinational encoder and accumulated here.
module booth_mult_seq #(parameter int WIDTH = 32) (
    input  logic          clk,
    input  logic          rst_n,
    booth_mult_if.master  bus
);
    localparam int STEPS = WIDTH / 2;
    localparam int SW    = $clog2(STEPS);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         r_state;
    logic [SW-1:0]      r_step;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_product;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH:0]     w_bext;
    logic [2*WIDTH-1:0] w_sum;
    logic               w_last;

    // Appending the implicit b[-1]=0 makes every window a plain 3-bit slice at bit 2k.
    assign w_bext = {r_b, 1'b0};
    assign w_sum  = r_acc + (bus.enc_p << {r_step, 1'b0});
    assign w_last = r_step == SW'(STEPS - 1);

    assign bus.busy     = r_state != IDLE;
    assign bus.done     = r_state == DONE;
    assign bus.product  = r_product;
    assign bus.enc_m    = r_a;
    assign bus.enc_bits = (r_state == RUN) ? w_bext[{r_step, 1'b0} +: 3] : 3'b000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_step    <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_a       <= '0;
            r_b       <= '0;
        end else if (r_state == IDLE && bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_acc   <= '0;
            r_step  <= '0;
            r_state <= RUN;
        end else if (r_state == RUN) begin
            r_acc  <= w_sum;
            r_step <= r_step + 1'b1;
            if (w_last) begin
                r_state   <= DONE;
                r_product <= w_sum;
            end
        end else if (r_state == DONE) begin
            r_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed and random checks of booth_mult_seq against plain signed
// multiplication, with an arithmetic Booth digit model acting as the encoder.
module tb_booth_mult_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    booth_mult_if #(.WIDTH(32)) bus ();
    booth_mult_seq #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Encoder: digit = -2*b2 + b1 + b0 times the sign-extended multiplicand.
    always_comb begin
        longint d;
        d = -2 * longint'(bus.enc_bits[2]) + longint'(bus.enc_bits[1]) + longint'(bus.enc_bits[0]);
        bus.enc_p = 64'(d * longint'($signed(bus.enc_m)));
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        longint ea, eb;
        ea = longint'($signed(a));
        eb = longint'($signed(b));
        return 64'(ea * eb);
    endfunction

    // Issues one multiply from a negedge and returns at the negedge after DONE (IDLE again).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        int n;
        logic m_ok;
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        n = 1;
        m_ok = 1'b1;
        while (!bus.done && n < 40) begin
            m_ok &= bus.busy && (bus.enc_m === a);
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd17);
        check({tag, "_product"}, bus.product, model(a, b));
        check({tag, "_enc_m_busy"}, {63'd0, m_ok & bus.busy}, 64'd1);
        @(negedge clk);
        check({tag, "_idle"}, {62'd0, bus.busy, bus.done}, 64'd0);
    endtask

    initial begin
        int k, dones;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        #12;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_product", bus.product, 64'd0);
        check("rst_enc_bits", {61'd0, bus.enc_bits}, 64'd0);
        check("rst_enc_m", {32'd0, bus.enc_m}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'd3, 32'd5, "p3x5");
        check("p3x5_const", bus.product, 64'h0000_0000_0000_000F);
        run_op(32'hFFFF_FFF9, 32'd6, "m7x6");
        check("m7x6_const", bus.product, 64'hFFFF_FFFF_FFFF_FFD6);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "m1xm1");
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, "maxpos");
        check("maxpos_const", bus.product, 64'h3FFF_FFFF_0000_0001);
        run_op(32'h8000_0000, 32'h8000_0000, "minneg");
        check("minneg_const", bus.product, 64'h4000_0000_0000_0000);
        run_op(32'h8000_0000, 32'd1, "minx1");
        check("minx1_const", bus.product, 64'hFFFF_FFFF_8000_0000);

        // Starts during RUN and DONE must be ignored.
        bus.start = 1'b1;
        bus.a = 32'd2;
        bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.a = 32'd9;
        bus.b = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        k = 7;
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("ign_latency", 64'(k), 64'd17);
        check("ign_product", bus.product, 64'd6);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("ign_done_start", {63'd0, bus.busy}, 64'd0);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            dones += int'(bus.done);
        end
        check("ign_no_extra_done", 64'(dones), 64'd0);
        check("ign_product_hold", bus.product, 64'd6);

        // Asynchronous reset in the middle of step 8.
        bus.start = 1'b1;
        bus.a = 32'd123;
        bus.b = 32'd456;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, bus.busy}, 64'd0);
        check("arst_done", {63'd0, bus.done}, 64'd0);
        check("arst_product", bus.product, 64'd0);
        check("arst_enc_bits", {61'd0, bus.enc_bits}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32'd4, 32'hFFFF_FFFC, "p4xm4");
        check("p4xm4_const", bus.product, 64'hFFFF_FFFF_FFFF_FFF0);

        for (int i = 0; i < 1000; i++)
            run_op($urandom, $urandom, "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
